motor_cmd_scheduler: RTL and testbench
======================================

Name: motor_cmd_scheduler

Overview:
- Per-channel command scheduler between the UART command parser and the ten motorCtrlSimple_v2 step generators.
- Accepts decoded move commands (channel, divider, step count, direction) and buffers them in a small per-channel queue.
- Presents each command to its motor once the motor is idle and confirms that the motor started, so moves run back-to-back with no host round trip.
- Replaces the single dataPending slot per motor and drives the pending/full status bitmaps reported over the UART.

Parameters:
NUM_CH, 10, number of motor channels (1..16)
DEPTH, 2, queue entries per channel; power of 2, at least 2
DIV_W, 15, divider field width
STEP_W, 15, step count field width
ACK_TIMEOUT, 64, cycles to wait for activeMode to rise after a load

Ports:
CLK  in  1  system clock (24 MHz)
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present on cmd_* this cycle
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_chan  in  4  target channel
cmd_divider  in  DIV_W  step period divider
cmd_steps  in  STEP_W  steps to go
cmd_dir  in  1  direction
cmd_sync  in  1  sync-start flag (used only with SYNC_START_EN)
drv_divider  out  NUM_CH*DIV_W  per-channel divider, channel c at [c*DIV_W +: DIV_W]
drv_steps  out  NUM_CH*STEP_W  per-channel stepsToGo
drv_dir  out  NUM_CH  per-channel dirInput
drv_active  in  NUM_CH  activeMode from each motor
pending  out  NUM_CH  channel queue not empty, or a move is in flight
full  out  NUM_CH  channel queue full
err  out  NUM_CH  sticky: ack timeout seen on the channel
bad_chan  out  1  one-cycle pulse: command to a channel >= NUM_CH was dropped

Behaviour:
- Reset (async, rst_n low): all queues empty, every channel in IDLE, drv_steps=0, drv_divider=0, drv_dir=0, pending=0, full=0, err=0, bad_chan=0. cmd_ready is combinational and reads 1 after reset.
- Accept rule: cmd_ready = 1 if cmd_chan >= NUM_CH, else ~full[cmd_chan].
  - Accepted command for a valid channel: written at the channel's write pointer in the same cycle.
  - Accepted command for a bad channel: discarded; bad_chan=1 on the next cycle.
- Queue pointers are log2(DEPTH)+1 bits wide; wrap modulo 2*DEPTH; full when the MSBs differ and the LSBs are equal.
- A write to a full queue cannot occur (cmd_ready=0). A write and a pop on the same channel in the same cycle are both honoured, and the count is unchanged.
- Per-channel FSM:
  - IDLE: if the queue is not empty and drv_active[c]=0, pop the head.
    - Head steps==0: discarded, stay IDLE.
    - Otherwise drive drv_divider/drv_steps/drv_dir from the head (registered, visible the next cycle), load the timer with ACK_TIMEOUT, go to LOAD.
  - LOAD: hold the drv_* values.
    - drv_active[c] rising (registered 0 to 1) → RUN, and drv_steps[c] is cleared to 0 that cycle so the motor does not retrigger.
    - Timer reaches 0 first → set err[c], clear drv_steps[c], go to IDLE.
  - RUN: wait for drv_active[c]=0.
    - When it falls → IDLE, and the next queued command is popped 1 cycle later at the earliest.
    - Load latency from the activeMode falling edge to the new drv_steps: 2 cycles.
- pending[c] = queue not empty OR state != IDLE. full[c] mirrors the queue. Both are registered, updated the cycle after the causing event.
- err[c] is cleared only by reset.
- drv_active high while a channel is in IDLE (a motor running without a scheduled move): no pop until it drops.
- Channels are fully independent. Simultaneous events on different channels never block each other.

Optional Feature:
SYNC_START_EN
- Defined: a popped command with cmd_sync=1 waits in a HOLD state with drv_steps=0 until every channel whose queue head or HOLD slot carries sync=1 is in HOLD. All of those channels then move to LOAD in the same cycle.
- Defined, timeout: a HOLD lasting longer than 16*ACK_TIMEOUT cycles releases the waiting channels individually and sets err on each of them.
- Undefined: cmd_sync is ignored, there is no HOLD state, and the sync bit is not stored (queue entry width reduced by 1).

Test Plan:
- Reset, push ch3 {div=100, steps=5, dir=1}, motor model raises active 3 cycles after load → drv_steps[ch3]=5 two cycles after accept, cleared to 0 on the active rise; pending[3] drops after active falls.
- Push 3 commands to ch0 while its motor is busy (DEPTH=2) → 3rd command sees cmd_ready=0 and full[0]=1. After active falls the next command loads 2 cycles later, and cmd_ready returns to 1 the cycle after the pop.
- Push to cmd_chan=12 → cmd_ready=1, bad_chan pulses for exactly 1 cycle, no drv_* change on any channel.
- Load ch5 with a motor model that never raises active → after 64 cycles err[5]=1 and drv_steps[ch5]=0; a subsequent command still executes normally.
- Command with steps=0 queued ahead of steps=7 on ch1 → only steps=7 is ever driven.
- With SYNC_START_EN: sync commands to ch2 and ch7 pushed 40 cycles apart → both drv_steps become nonzero in the same cycle.

Source files
------------

// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - per-channel move queues feeding motor step generators; optional SYNC_START_EN sync-start hold
module motor_cmd_scheduler #(
  parameter int NUM_CH      = 10,
  parameter int DEPTH       = 2,
  parameter int DIV_W       = 15,
  parameter int STEP_W      = 15,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_chan,
  input  logic [DIV_W-1:0]         cmd_divider,
  input  logic [STEP_W-1:0]        cmd_steps,
  input  logic                     cmd_dir,
  input  logic                     cmd_sync,
  output logic [NUM_CH*DIV_W-1:0]  drv_divider,
  output logic [NUM_CH*STEP_W-1:0] drv_steps,
  output logic [NUM_CH-1:0]        drv_dir,
  input  logic [NUM_CH-1:0]        drv_active,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        err,
  output logic                     bad_chan
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
`ifdef SYNC_START_EN
  localparam int EW   = DIV_W + STEP_W + 2;
  localparam int HT_W = $clog2(16 * ACK_TIMEOUT + 1);
  localparam logic [1:0] ST_HOLD = 2'd3;
`else
  localparam int EW = DIV_W + STEP_W + 1;
`endif
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic              chan_ok;
  logic [15:0]       full_w;
  logic [NUM_CH-1:0] full_vec;
  logic [EW-1:0]     cmd_entry;
  logic              bad_chan_q;

  assign chan_ok   = {1'b0, cmd_chan} < 5'(NUM_CH);
  assign full_w    = 16'(full_vec);
  assign cmd_ready = chan_ok ? ~full_w[cmd_chan] : 1'b1;
  assign full      = full_vec;
  assign bad_chan  = bad_chan_q;

`ifdef SYNC_START_EN
  logic [NUM_CH-1:0] need_vec;
  logic [NUM_CH-1:0] hold_vec;
  logic              sync_go;
  assign cmd_entry = {cmd_sync, cmd_dir, cmd_steps, cmd_divider};
  // Release only when every sync participant has reached HOLD
  assign sync_go   = (&(~need_vec | hold_vec)) && (|hold_vec);
`else
  logic unused_sync;
  assign unused_sync = cmd_sync;
  assign cmd_entry   = {cmd_dir, cmd_steps, cmd_divider};
`endif

  // Commands to nonexistent channels are swallowed and flagged one cycle later
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) bad_chan_q <= 1'b0;
    else        bad_chan_q <= cmd_valid && !chan_ok;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]        st_q, st_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              dir_q, dir_d, err_q, err_d, act_q, pend_q, full_q;
    logic              wr, pop, empty;
    logic [EW-1:0]     head;
    logic [DIV_W-1:0]  h_div;
    logic [STEP_W-1:0] h_steps;
    logic              h_dir;

    assign wr      = cmd_valid && cmd_ready && chan_ok && (cmd_chan == 4'(c));
    assign empty   = (wptr_q == rptr_q);
    assign head    = mem_q[rptr_q[AW-1:0]];
    assign h_div   = head[DIV_W-1:0];
    assign h_steps = head[DIV_W +: STEP_W];
    assign h_dir   = head[DIV_W+STEP_W];
    assign wptr_d  = wptr_q + PW'(wr);
    assign rptr_d  = rptr_q + PW'(pop);

`ifdef SYNC_START_EN
    logic [STEP_W-1:0] hsteps_q, hsteps_d;
    logic [HT_W-1:0]   htmr_q, htmr_d;
    assign need_vec[c] = (st_q == ST_HOLD) || (!empty && head[EW-1]);
    assign hold_vec[c] = (st_q == ST_HOLD);
`endif

    // Queue storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge CLK) begin
      if (wr) mem_q[wptr_q[AW-1:0]] <= cmd_entry;
    end

    // Channel sequencer: pop head when motor idle, wait for activeMode ack, then for completion
    always_comb begin
      st_d    = st_q;
      tmr_d   = tmr_q;
      div_d   = div_q;
      steps_d = steps_q;
      dir_d   = dir_q;
      err_d   = err_q;
      pop     = 1'b0;
`ifdef SYNC_START_EN
      hsteps_d = hsteps_q;
      htmr_d   = htmr_q;
`endif
      case (st_q)
        ST_IDLE: begin
          if (!empty && !drv_active[c]) begin
            pop = 1'b1;
            if (h_steps != '0) begin
              div_d   = h_div;
              dir_d   = h_dir;
              steps_d = h_steps;
              tmr_d   = TW'(ACK_TIMEOUT);
              st_d    = ST_LOAD;
`ifdef SYNC_START_EN
              if (head[EW-1]) begin
                hsteps_d = h_steps;
                steps_d  = '0;
                htmr_d   = HT_W'(16 * ACK_TIMEOUT);
                st_d     = ST_HOLD;
              end
`endif
            end
          end
        end
        ST_LOAD: begin
          if (drv_active[c] && !act_q) begin
            steps_d = '0;
            st_d    = ST_RUN;
          end else if (tmr_q <= TW'(1)) begin
            err_d   = 1'b1;
            steps_d = '0;
            st_d    = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_RUN: begin
          if (!drv_active[c]) st_d = ST_IDLE;
        end
`ifdef SYNC_START_EN
        ST_HOLD: begin
          if (sync_go || htmr_q == '0) begin
            steps_d = hsteps_q;
            tmr_d   = TW'(ACK_TIMEOUT);
            st_d    = ST_LOAD;
            if (!sync_go) err_d = 1'b1;
          end else begin
            htmr_d = htmr_q - HT_W'(1);
          end
        end
`endif
        default: st_d = ST_IDLE;
      endcase
    end

    // Channel state, pointers and registered status flags
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        st_q    <= ST_IDLE;
        tmr_q   <= '0;
        div_q   <= '0;
        steps_q <= '0;
        dir_q   <= 1'b0;
        err_q   <= 1'b0;
        act_q   <= 1'b0;
        pend_q  <= 1'b0;
        full_q  <= 1'b0;
`ifdef SYNC_START_EN
        hsteps_q <= '0;
        htmr_q   <= '0;
`endif
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        st_q    <= st_d;
        tmr_q   <= tmr_d;
        div_q   <= div_d;
        steps_q <= steps_d;
        dir_q   <= dir_d;
        err_q   <= err_d;
        act_q   <= drv_active[c];
        pend_q  <= (wptr_d != rptr_d) || (st_d != ST_IDLE);
        full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
`ifdef SYNC_START_EN
        hsteps_q <= hsteps_d;
        htmr_q   <= htmr_d;
`endif
      end
    end

    assign drv_divider[c*DIV_W +: DIV_W]  = div_q;
    assign drv_steps[c*STEP_W +: STEP_W]  = steps_q;
    assign drv_dir[c]                     = dir_q;
    assign pending[c]                     = pend_q;
    assign full_vec[c]                    = full_q;
    assign err[c]                         = err_q;
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - self-checking bench for motor_cmd_scheduler with motor model and scoreboard
module tb_motor_cmd_scheduler;
  localparam int NUM_CH = 10;
  localparam int W      = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [3:0]         cmd_chan = '0;
  logic [W-1:0]       cmd_divider = '0;
  logic [W-1:0]       cmd_steps = '0;
  logic               cmd_dir = 1'b0;
  logic               cmd_sync = 1'b0;
  logic [NUM_CH*W-1:0] drv_divider, drv_steps;
  logic [NUM_CH-1:0]  drv_dir, pending, full, err;
  logic [NUM_CH-1:0]  drv_active = '0;
  logic               bad_chan;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  motor_cmd_scheduler dut (
    .CLK(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_divider(cmd_divider), .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir), .cmd_sync(cmd_sync), .drv_divider(drv_divider),
    .drv_steps(drv_steps), .drv_dir(drv_dir), .drv_active(drv_active),
    .pending(pending), .full(full), .err(err), .bad_chan(bad_chan)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] stp(input int c);
    return drv_steps[c*W +: W];
  endfunction
  function automatic logic [W-1:0] dvr(input int c);
    return drv_divider[c*W +: W];
  endfunction

  // Motor model: after seeing nonzero steps, raise activeMode ack_dly cycles later, hold it for a run
  int ack_dly [NUM_CH];
  int run_len [NUM_CH];
  bit never_ack [NUM_CH];
  int m_dly [NUM_CH];
  int m_left [NUM_CH];
  bit m_busy [NUM_CH];
  initial for (int c = 0; c < NUM_CH; c++) begin
    ack_dly[c] = 3; run_len[c] = 0; never_ack[c] = 0; m_dly[c] = 0; m_left[c] = 0; m_busy[c] = 0;
  end

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_busy[c]) begin
        if (m_left[c] == 0) begin drv_active[c] = 1'b0; m_busy[c] = 0; end
        else m_left[c]--;
      end else if (m_dly[c] != 0) begin
        m_dly[c]--;
        if (m_dly[c] == 0) begin
          drv_active[c] = 1'b1;
          m_busy[c] = 1;
          m_left[c] = (run_len[c] != 0) ? run_len[c] : int'($urandom_range(1, 6));
        end
      end else if (stp(c) != 0 && !never_ack[c]) begin
        m_dly[c] = ack_dly[c];
      end
    end
  end

  // Reference model: per-channel FIFO of accepted nonzero moves, matched against each new load
  typedef struct packed {logic [W-1:0] dv; logic [W-1:0] st; logic d;} cmd_t;
  cmd_t        expq [NUM_CH][$];
  cmd_t        e;
  logic [W-1:0] prev_steps [NUM_CH];
  logic [W-1:0] sb_s;
  logic        exp_bad = 1'b0;
  bit          sb_en = 0;

  initial for (int c = 0; c < NUM_CH; c++) prev_steps[c] = '0;

  always @(negedge clk) begin
    if (sb_en) begin
      chk("bad_chan pulse", 32'(bad_chan), 32'(exp_bad));
      for (int c = 0; c < NUM_CH; c++) begin
        sb_s = stp(c);
        if (prev_steps[c] == 0 && sb_s != 0) begin
          if (expq[c].size() == 0) begin
            chk("sb unexpected load", 32'(sb_s), 32'(0));
          end else begin
            e = expq[c].pop_front();
            chk("sb steps", 32'(sb_s), 32'(e.st));
            chk("sb divider", 32'(dvr(c)), 32'(e.dv));
            chk("sb dir", 32'(drv_dir[c]), 32'(e.d));
          end
        end
      end
      if (cmd_valid && cmd_ready && cmd_chan < 4'(NUM_CH) && cmd_steps != 0)
        expq[cmd_chan].push_back('{dv: cmd_divider, st: cmd_steps, d: cmd_dir});
    end
    for (int c = 0; c < NUM_CH; c++) prev_steps[c] = stp(c);
    exp_bad = cmd_valid && (cmd_chan >= 4'(NUM_CH));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input int ch, input int dv, input int st, input bit d);
    cmd_valid = 1'b1; cmd_chan = 4'(ch); cmd_divider = W'(dv); cmd_steps = W'(st); cmd_dir = d;
    @(negedge clk);
    chk("push ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_active(input int c, input logic v, input int max);
    int n = 0;
    while (drv_active[c] !== v && n < max) begin @(negedge clk); n++; end
    chk("wait activeMode", 32'(drv_active[c] === v), 32'(1));
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    @(negedge clk);
    while (pending !== '0 && n < max) begin @(negedge clk); n++; end
    chk("drain pending", 32'(pending), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(cmd_ready), 32'(1));
    chk("reset pending", 32'(pending), 32'(0));
    chk("reset full", 32'(full), 32'(0));
    chk("reset err", 32'(err), 32'(0));
    chk("reset bad_chan", 32'(bad_chan), 32'(0));
    chk("reset steps", 32'(|drv_steps), 32'(0));
    chk("reset divider", 32'(|drv_divider), 32'(0));
    chk("reset dir", 32'(drv_dir), 32'(0));

    // Single move on ch3 with acknowledge 3 cycles after load
    run_len[3] = 6;
    step();
    push(3, 100, 5, 1);
    @(negedge clk);
    chk("ch3 not yet loaded", 32'(stp(3)), 32'(0));
    chk("ch3 pending", 32'(pending[3]), 32'(1));
    @(negedge clk);
    chk("ch3 steps", 32'(stp(3)), 32'(5));
    chk("ch3 divider", 32'(dvr(3)), 32'(100));
    chk("ch3 dir", 32'(drv_dir[3]), 32'(1));
    wait_active(3, 1'b1, 20);
    @(negedge clk);
    chk("ch3 steps cleared on ack", 32'(stp(3)), 32'(0));
    chk("ch3 pending while run", 32'(pending[3]), 32'(1));
    wait_active(3, 1'b0, 40);
    @(negedge clk);
    chk("ch3 pending dropped", 32'(pending[3]), 32'(0));

    // Fill ch0 while its motor is busy
    run_len[0] = 40;
    step();
    push(0, 10, 3, 0);
    wait_active(0, 1'b1, 20);
    step();
    push(0, 11, 4, 1);
    push(0, 12, 6, 0);
    cmd_valid = 1'b1; cmd_chan = 4'd0; cmd_divider = 15'd13; cmd_steps = 15'd2; cmd_dir = 1'b1;
    @(negedge clk);
    chk("ch0 full ready", 32'(cmd_ready), 32'(0));
    chk("ch0 full flag", 32'(full[0]), 32'(1));
    cmd_valid = 1'b0;
    wait_active(0, 1'b0, 60);
    @(negedge clk);
    chk("ch0 load +1", 32'(stp(0)), 32'(0));
    chk("ch0 ready before pop", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    chk("ch0 load +2 steps", 32'(stp(0)), 32'(4));
    chk("ch0 load +2 divider", 32'(dvr(0)), 32'(11));
    chk("ch0 ready after pop", 32'(cmd_ready), 32'(1));
    chk("ch0 full cleared", 32'(full[0]), 32'(0));
    step();
    push(0, 13, 2, 1);
    wait_drain(400);
    run_len[0] = 0;

    // Command to nonexistent channel
    step();
    cmd_valid = 1'b1; cmd_chan = 4'd12; cmd_steps = 15'd9; cmd_divider = 15'd9;
    @(negedge clk);
    chk("bad ready", 32'(cmd_ready), 32'(1));
    chk("bad before", 32'(bad_chan), 32'(0));
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bad pulse", 32'(bad_chan), 32'(1));
    @(negedge clk);
    chk("bad pulse end", 32'(bad_chan), 32'(0));
    chk("bad no steps", 32'(|drv_steps), 32'(0));
    chk("bad no pending", 32'(pending), 32'(0));

    // Ack timeout on ch5, then normal move
    never_ack[5] = 1;
    step();
    push(5, 7, 9, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ch5 loaded", 32'(stp(5)), 32'(9));
    repeat (60) @(negedge clk);
    chk("ch5 err early", 32'(err[5]), 32'(0));
    chk("ch5 held", 32'(stp(5)), 32'(9));
    repeat (6) @(negedge clk);
    chk("ch5 err set", 32'(err[5]), 32'(1));
    chk("ch5 steps cleared", 32'(stp(5)), 32'(0));
    chk("ch5 idle", 32'(pending[5]), 32'(0));
    never_ack[5] = 0;
    step();
    push(5, 8, 4, 1);
    @(negedge clk);
    @(negedge clk);
    chk("ch5 retry steps", 32'(stp(5)), 32'(4));
    wait_active(5, 1'b1, 20);
    wait_active(5, 1'b0, 40);
    @(negedge clk);
    chk("ch5 err sticky", 32'(err[5]), 32'(1));
    chk("ch5 done", 32'(pending[5]), 32'(0));

    // Zero-step command is dropped ahead of a real one
    step();
    push(1, 20, 0, 0);
    push(1, 33, 7, 1);
    @(negedge clk);
    chk("ch1 zero not driven", 32'(dvr(1)), 32'(0));
    @(negedge clk);
    chk("ch1 steps", 32'(stp(1)), 32'(7));
    chk("ch1 divider", 32'(dvr(1)), 32'(33));
    wait_drain(100);

    // Randomized traffic against the FIFO reference model
    for (int c = 0; c < NUM_CH; c++) ack_dly[c] = int'($urandom_range(1, 5));
    sb_en = 1;
    for (int k = 0; k < 800; k++) begin
      step();
      cmd_valid   = ($urandom_range(0, 1) == 1);
      cmd_chan    = 4'($urandom_range(0, 11));
      cmd_divider = 15'($urandom_range(1, 3000));
      cmd_steps   = ($urandom_range(0, 5) == 0) ? 15'd0 : 15'($urandom_range(1, 500));
      cmd_dir     = 1'($urandom_range(0, 1));
    end
    step();
    cmd_valid = 1'b0;
    wait_drain(3000);
    @(negedge clk);
    sb_en = 0;
    for (int c = 0; c < NUM_CH; c++) chk("sb leftover", 32'(expq[c].size()), 32'(0));
    chk("random err", 32'(err & ~(10'b1 << 5)), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
